// File: rtl/drive_mode_arbiter.sv
// Drive-mode arbiter: power sequencing, manual/auto source selection,
// mode-change handshake and saturating mileage for the car controller.
module drive_mode_arbiter #(
  parameter int PWR_HOLD   = 1000,
  parameter int IDLE_LIMIT = 10000,
  parameter int MILE_DIV   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        power_btn,
  input  logic        mode_btn,
  input  logic [1:0]  mode_sel,
  input  logic [1:0]  man_state,
  input  logic [3:0]  man_moving,
  input  logic        man_power,
  input  logic [1:0]  auto_state,
  input  logic [3:0]  auto_moving,
  input  logic        auto_valid,
  output logic        power,
  output logic [1:0]  global_state,
  output logic [1:0]  state,
  output logic [3:0]  moving_state,
  output logic        mode_ack,
  output logic        mode_nack,
  output logic [13:0] mile_cnt
);

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_SWITCH = 2'b10;

  localparam logic [1:0] CAR_NSTART   = 2'b00;
  localparam logic [1:0] CAR_MOVING   = 2'b10;
  localparam logic [1:0] MODE_MANUAL  = 2'b00;
  localparam logic [1:0] MODE_INVALID = 2'b11;
  localparam logic [3:0] MOVE_NONE    = 4'b0000;

  localparam int HOLD_W = $clog2(PWR_HOLD + 1);
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam int PRE_W  = $clog2(MILE_DIV + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PWR_HOLD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MILE_DIV - 1);
  localparam logic [13:0]       MILE_MAX  = 14'd9999;

  function automatic logic [13:0] mile_sat_inc(input logic [13:0] m);
    return (m >= MILE_MAX) ? MILE_MAX : m + 14'd1;
  endfunction

  logic [1:0]        fsm_q, fsm_d;
  logic [1:0]        gstate_q, gstate_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        moving_q, moving_d;
  logic              ack_q, ack_d;
  logic              nack_q, nack_d;
  logic [13:0]       mile_q, mile_d;
  logic [1:0]        sel_q, sel_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lock_q, lock_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [PRE_W-1:0]  pre_q, pre_step;
  logic [PRE_W-1:0]  pre_d;
  logic              btn_prev_q;

  logic hold_exp, idle_exp, mile_en, in_idle, in_motion, mode_req, off_cause;
  logic [13:0] mile_step;

  // Power button hold: a completed hold locks out until the button is released.
  always_comb begin
    hold_d   = hold_q;
    lock_d   = lock_q;
    hold_exp = 1'b0;
    if (!power_btn) begin
      hold_d = '0;
      lock_d = 1'b0;
    end else if (tick && !lock_q) begin
      if (hold_q == HOLD_LAST) begin
        hold_d   = '0;
        lock_d   = 1'b1;
        hold_exp = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    in_idle  = (fsm_q != ST_OFF) && (state_q == CAR_NSTART) && (moving_q == MOVE_NONE);
    idle_d   = idle_q;
    idle_exp = 1'b0;
    if (!in_idle) begin
      idle_d = '0;
    end else if (tick) begin
      if (idle_q == IDLE_LAST) begin
        idle_d   = '0;
        idle_exp = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_comb begin
    in_motion = (fsm_q == ST_RUN) && (state_q == CAR_MOVING) && (moving_q != MOVE_NONE);
    pre_step  = pre_q;
    mile_en   = 1'b0;
    if (in_motion && tick) begin
      if (pre_q == PRE_LAST) begin
        pre_step = '0;
        mile_en  = 1'b1;
      end else begin
        pre_step = pre_q + PRE_W'(1);
      end
    end
    mile_step = mile_en ? mile_sat_inc(mile_q) : mile_q;
  end

  assign mode_req  = mode_btn && !btn_prev_q;
  assign off_cause = hold_exp || idle_exp || (!man_power && (gstate_q == MODE_MANUAL));

  // Power-off beats a mode request, which beats the source mux update.
  // A rejected request still lets the source mux update that cycle.
  always_comb begin
    fsm_d    = fsm_q;
    gstate_d = gstate_q;
    state_d  = state_q;
    moving_d = moving_q;
    sel_d    = sel_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    mile_d   = mile_step;
    pre_d    = pre_step;
    case (fsm_q)
      ST_OFF: begin
        if (hold_exp) begin
          fsm_d    = ST_RUN;
          gstate_d = MODE_MANUAL;
          state_d  = CAR_NSTART;
          moving_d = MOVE_NONE;
          mile_d   = '0;
          pre_d    = '0;
        end
      end
      ST_SWITCH: begin
        if (off_cause) begin
          fsm_d    = ST_OFF;
          gstate_d = MODE_MANUAL;
          state_d  = CAR_NSTART;
          moving_d = MOVE_NONE;
        end else begin
          fsm_d    = ST_RUN;
          gstate_d = sel_q;
          state_d  = CAR_NSTART;
          moving_d = MOVE_NONE;
        end
      end
      ST_RUN: begin
        if (off_cause) begin
          fsm_d    = ST_OFF;
          gstate_d = MODE_MANUAL;
          state_d  = CAR_NSTART;
          moving_d = MOVE_NONE;
        end else if (mode_req && (state_q == CAR_NSTART) && (mode_sel != MODE_INVALID)) begin
          fsm_d    = ST_SWITCH;
          ack_d    = 1'b1;
          sel_d    = mode_sel;
          state_d  = CAR_NSTART;
          moving_d = MOVE_NONE;
        end else begin
          nack_d = mode_req;
          if (gstate_q == MODE_MANUAL) begin
            state_d  = man_state;
            moving_d = man_moving;
          end else if (auto_valid) begin
            state_d  = auto_state;
            moving_d = auto_moving;
          end
        end
      end
      default: begin
        fsm_d    = ST_OFF;
        gstate_d = MODE_MANUAL;
        state_d  = CAR_NSTART;
        moving_d = MOVE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q      <= ST_OFF;
      gstate_q   <= MODE_MANUAL;
      state_q    <= CAR_NSTART;
      moving_q   <= MOVE_NONE;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      mile_q     <= '0;
      sel_q      <= MODE_MANUAL;
      hold_q     <= '0;
      lock_q     <= 1'b0;
      idle_q     <= '0;
      pre_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      gstate_q   <= gstate_d;
      state_q    <= state_d;
      moving_q   <= moving_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      mile_q     <= mile_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      lock_q     <= lock_d;
      idle_q     <= idle_d;
      pre_q      <= pre_d;
      btn_prev_q <= mode_btn;
    end
  end

  assign power        = (fsm_q != ST_OFF);
  assign global_state = gstate_q;
  assign state        = state_q;
  assign moving_state = moving_q;
  assign mode_ack     = ack_q;
  assign mode_nack    = nack_q;
  assign mile_cnt     = mile_q;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Scoreboarded bench: a cycle-level rule model predicts every output word,
// a monitor compares the DUT against the queued predictions.
module tb_drive_mode_arbiter;

  localparam int PWR_HOLD   = 4;
  localparam int IDLE_LIMIT = 20;
  localparam int MILE_DIV   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        power_btn = 1'b0;
  logic        mode_btn = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [1:0]  man_state = 2'b00;
  logic [3:0]  man_moving = 4'b0000;
  logic        man_power = 1'b1;
  logic [1:0]  auto_state = 2'b00;
  logic [3:0]  auto_moving = 4'b0000;
  logic        auto_valid = 1'b0;
  logic        power;
  logic [1:0]  global_state;
  logic [1:0]  state;
  logic [3:0]  moving_state;
  logic        mode_ack;
  logic        mode_nack;
  logic [13:0] mile_cnt;

  drive_mode_arbiter #(
    .PWR_HOLD(PWR_HOLD), .IDLE_LIMIT(IDLE_LIMIT), .MILE_DIV(MILE_DIV)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .power_btn(power_btn),
    .mode_btn(mode_btn), .mode_sel(mode_sel), .man_state(man_state),
    .man_moving(man_moving), .man_power(man_power), .auto_state(auto_state),
    .auto_moving(auto_moving), .auto_valid(auto_valid), .power(power),
    .global_state(global_state), .state(state), .moving_state(moving_state),
    .mode_ack(mode_ack), .mode_nack(mode_nack), .mile_cnt(mile_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [24:0] exp_q[$];

  // Reference model: vehicle mode as 0 off / 1 running / 2 switching
  int         m_mode = 0;
  logic [1:0] m_gs = 0, m_st = 0, m_sel = 0;
  logic [3:0] m_mv = 0;
  bit         m_ack = 0, m_nack = 0, m_lock = 0, m_prev = 0;
  int         m_mile = 0, m_hold = 0, m_idle = 0, m_pre = 0;

  task automatic model_step();
    bit hold_fire, idle_fire, kill, req;
    if (!rst) begin
      m_mode = 0; m_gs = 0; m_st = 0; m_mv = 0; m_sel = 0;
      m_ack = 0; m_nack = 0; m_lock = 0; m_prev = 0;
      m_mile = 0; m_hold = 0; m_idle = 0; m_pre = 0;
    end else begin
      hold_fire = 0;
      if (!power_btn) begin
        m_hold = 0; m_lock = 0;
      end else if (tick && !m_lock) begin
        m_hold++;
        if (m_hold >= PWR_HOLD) begin hold_fire = 1; m_hold = 0; m_lock = 1; end
      end
      idle_fire = 0;
      if (m_mode != 0 && m_st == 0 && m_mv == 0) begin
        if (tick) begin
          m_idle++;
          if (m_idle >= IDLE_LIMIT) begin idle_fire = 1; m_idle = 0; end
        end
      end else begin
        m_idle = 0;
      end
      if (m_mode == 1 && m_st == 2 && m_mv != 0 && tick) begin
        m_pre++;
        if (m_pre >= MILE_DIV) begin
          m_pre = 0;
          if (m_mile < 9999) m_mile++;
        end
      end
      req = mode_btn && !m_prev;
      m_prev = mode_btn;
      kill = hold_fire || idle_fire || (!man_power && m_gs == 0);
      m_ack = 0; m_nack = 0;
      if (m_mode == 0) begin
        if (hold_fire) begin
          m_mode = 1; m_gs = 0; m_st = 0; m_mv = 0; m_mile = 0; m_pre = 0;
        end
      end else if (kill) begin
        m_mode = 0; m_gs = 0; m_st = 0; m_mv = 0;
      end else if (m_mode == 2) begin
        m_mode = 1; m_gs = m_sel; m_st = 0; m_mv = 0;
      end else if (req && m_st == 0 && mode_sel != 2'b11) begin
        m_mode = 2; m_ack = 1; m_sel = mode_sel; m_st = 0; m_mv = 0;
      end else begin
        m_nack = req;
        if (m_gs == 0) begin
          m_st = man_state; m_mv = man_moving;
        end else if (auto_valid) begin
          m_st = auto_state; m_mv = auto_moving;
        end
      end
    end
    exp_q.push_back({(m_mode != 0), m_gs, m_st, m_mv, m_ack, m_nack, 14'(m_mile)});
  endtask

  // Inputs are set before calling; one clock edge consumes them.
  task automatic run_cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; run_cycle();
      tick = 1'b0; run_cycle();
    end
  endtask

  task automatic power_toggle();
    power_btn = 1'b1; ticks(PWR_HOLD);
    power_btn = 1'b0; run_cycle();
  endtask

  task automatic press_mode(input logic [1:0] sel);
    mode_sel = sel;
    mode_btn = 1'b1; run_cycle();
    mode_btn = 1'b0; run_cycle();
  endtask

  initial begin : monitor
    logic [24:0] exp, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {power, global_state, state, moving_state, mode_ack, mode_nack, mile_cnt};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL outputs t=%0t actual pwr=%b gs=%b st=%b mv=%b ack=%b nack=%b mile=%0d required pwr=%b gs=%b st=%b mv=%b ack=%b nack=%b mile=%0d",
                   $time, act[24], act[23:22], act[21:20], act[19:16], act[15], act[14], act[13:0],
                   exp[24], exp[23:22], exp[21:20], exp[19:16], exp[15], exp[14], exp[13:0]);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset with a held power button: must not count.
    power_btn = 1'b1; tick = 1'b1;
    repeat (3) run_cycle();
    rst = 1'b1; power_btn = 1'b0; tick = 1'b0; run_cycle();

    // Short hold does nothing, full hold powers on, continued hold does not re-toggle.
    power_btn = 1'b1; ticks(3);
    power_btn = 1'b0; run_cycle();
    power_btn = 1'b1; ticks(PWR_HOLD + 3);
    power_btn = 1'b0; run_cycle();

    // Manual motion and mileage.
    man_power = 1'b1; man_state = 2'b10; man_moving = 4'b0001; run_cycle();
    ticks(9);
    // Request while moving is rejected.
    press_mode(2'b10);
    man_state = 2'b00; man_moving = 4'b0000; run_cycle();
    press_mode(2'b11);
    press_mode(2'b10);
    run_cycle();

    // Auto mode: valid loads, invalid holds.
    auto_valid = 1'b1; auto_state = 2'b10; auto_moving = 4'b0010; run_cycle();
    auto_valid = 1'b0; auto_state = 2'b01; auto_moving = 4'b1000; ticks(2);
    press_mode(2'b01);
    auto_valid = 1'b1; auto_state = 2'b00; auto_moving = 4'b0000; run_cycle();
    auto_valid = 1'b0;
    press_mode(2'b00);
    run_cycle();

    // Manual power request off.
    man_power = 1'b0; run_cycle(); run_cycle();
    man_power = 1'b1;

    // Idle timeout.
    power_toggle();
    ticks(IDLE_LIMIT + 2);

    // Mileage saturation.
    power_toggle();
    man_state = 2'b10; man_moving = 4'b0100; run_cycle();
    tick = 1'b1;
    repeat (9999 * MILE_DIV + 40) run_cycle();
    tick = 1'b0;
    man_state = 2'b00; man_moving = 4'b0000; run_cycle();

    // Reset in the SWITCH cycle.
    mode_sel = 2'b10; mode_btn = 1'b1; run_cycle();
    rst = 1'b0; mode_btn = 1'b0; run_cycle();
    rst = 1'b1; run_cycle(); run_cycle();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) != 0);
      tick       = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) power_btn = ~power_btn;
      if ($urandom_range(0, 3) == 0) mode_btn = ~mode_btn;
      mode_sel   = 2'($urandom_range(0, 3));
      man_state  = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0: man_moving = 4'b0000;
        1: man_moving = 4'b0001;
        2: man_moving = 4'b0010;
        3: man_moving = 4'b0100;
        default: man_moving = 4'b1000;
      endcase
      man_power   = ($urandom_range(0, 63) != 0);
      auto_state  = 2'($urandom_range(0, 2));
      auto_moving = 4'(1 << $urandom_range(0, 3)) & {4{$urandom_range(0, 3) != 0}};
      auto_valid  = $urandom_range(0, 1);
      run_cycle();
    end

    rst = 1'b1; power_btn = 1'b0; mode_btn = 1'b0; tick = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
